// File: rtl/display_pkg.sv
// display_pkg: glyph table, display mode and blank constant shared by the scan controller
package display_pkg;
  typedef enum logic {MODE_HEX = 1'b0, MODE_DEC = 1'b1} mode_e;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  // Active-high {a,b,c,d,e,f,g,dp}; entry 0 is the rightmost byte.
  localparam logic [15:0][7:0] GLYPH = {
    8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hE6, 8'hFE,
    8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
  };
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble converter, one shift per cycle
// Ports: start_i starts a conversion of bin_i when idle; busy_o is high for W cycles;
//        done_o marks the last busy cycle, during which bcd_o carries the final result.
module bin2bcd_seq #(
  parameter int W = 32,
  parameter int D = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [W-1:0]   bin_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [4*D-1:0] bcd_o
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0]   sh_q;
  logic [4*D-1:0] bcd_q, adj, bcd_d;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < D; i++)
      adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
    bcd_d = (adj << 1) | (4*D)'(sh_q[W-1]);
  end
  // The result is taken from the next-state value so the consumer can latch it on the
  // same edge that busy falls.
  assign bcd_o  = bcd_d;
  assign busy_o = busy_q;
  assign done_o = busy_q && cnt_q == CW'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (busy_q) begin
      sh_q   <= sh_q << 1;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_q - 1'b1;
      busy_q <= !done_o;
    end else if (start_i) begin
      sh_q   <= bin_i;
      bcd_q  <= '0;
      cnt_q  <= CW'(W);
      busy_q <= 1'b1;
    end
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed N-digit 7-segment scanner with hex/decimal display and PWM
// Ports: en blanks all outputs when low; load captures data_in (hex) or starts a decimal
//        conversion (mode=1); dp_mask/blank_lz/brightness shape the glyphs; seg/anode drive
//        the board; busy flags a conversion; overflow flags an out-of-range decimal load.
module display_scan_ctrl import display_pkg::*; #(
  parameter int N_DIGITS       = 8,
  parameter int TICK_DIV       = 100000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic                  load,
  input  logic                  mode,
  input  logic [N_DIGITS-1:0]   dp_mask,
  input  logic                  blank_lz,
  input  logic [3:0]            brightness,
  output logic [7:0]            seg,
  output logic [N_DIGITS-1:0]   anode,
  output logic                  busy,
  output logic                  overflow
);
  localparam int W    = 4 * N_DIGITS;
  localparam int D    = N_DIGITS + 2;
  localparam int SLOT = TICK_DIV / 16;
  localparam int PRW  = $clog2(TICK_DIV);
  localparam int IW   = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam logic [7:0]          SEG_OFF = SEG_ACTIVE_LOW != 0 ? 8'hFF : 8'h00;
  localparam logic [N_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW != 0 ? {N_DIGITS{1'b1}} : '0;
  logic [PRW-1:0]      pre_q, pre_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [W-1:0]        shown_q, shown_d;
  logic                ovf_q, ovf_d;
  logic [7:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic                start, conv_busy, conv_done;
  logic [4*D-1:0]      bcd;
  logic [N_DIGITS-1:0] nz;
  logic                acc, on;
  logic [3:0]          phase, dig;
  logic [7:0]          glyph;
  assign start = load && !conv_busy && mode == MODE_DEC;
  bin2bcd_seq #(.W(W), .D(D)) u_bcd (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(start),
    .bin_i  (data_in),
    .busy_o (conv_busy),
    .done_o (conv_done),
    .bcd_o  (bcd)
  );
  always_comb begin
    pre_d   = pre_q;
    idx_d   = idx_q;
    shown_d = shown_q;
    ovf_d   = ovf_q;
    nz      = '0;
    acc     = 1'b0;
    if (en) begin
      pre_d = pre_q == PRW'(TICK_DIV - 1) ? '0 : pre_q + 1'b1;
      if (pre_q == PRW'(TICK_DIV - 1))
        idx_d = idx_q == IW'(N_DIGITS - 1) ? '0 : idx_q + 1'b1;
    end
    // The two extra BCD digits only ever hold range overflow.
    if (conv_done) begin
      ovf_d   = |bcd[4*D-1:W];
      shown_d = ovf_d ? {N_DIGITS{4'hE}} : bcd[W-1:0];
    end else if (load && !conv_busy && mode == MODE_HEX) begin
      shown_d = data_in;
      ovf_d   = 1'b0;
    end
    // nz[i]: digit i or any digit above it is nonzero.
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      acc   = acc | (|shown_q[4*i+:4]);
      nz[i] = acc;
    end
    phase = 4'(pre_q / PRW'(SLOT));
    dig   = shown_q[4*idx_q+:4];
    glyph = blank_lz && idx_q != '0 && !nz[idx_q] ? SEG_BLANK : GLYPH[dig];
    on    = en && phase <= brightness;
    seg_d = on ? {glyph[7:1], glyph[0] | dp_mask[idx_q]} ^ SEG_OFF : SEG_OFF;
    an_d  = on ? (N_DIGITS'(1) << idx_q) ^ AN_OFF : AN_OFF;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pre_q   <= '0;
      idx_q   <= '0;
      shown_q <= '0;
      ovf_q   <= 1'b0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      shown_q <= shown_d;
      ovf_q   <= ovf_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  assign seg      = seg_q;
  assign anode    = an_q;
  assign busy     = conv_busy;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: randomized scoreboard bench for display_scan_ctrl
module tb_display_scan_ctrl;
  localparam int N  = 8;
  localparam int TD = 32;
  logic        clk = 0, rst_n = 0, en = 0, load = 0, mode = 0, blank_lz = 0;
  logic [31:0] data_in = 0;
  logic [7:0]  dp_mask = 0;
  logic [3:0]  brightness = 15;
  logic [7:0]  seg, anode;
  logic        busy, overflow;
  display_scan_ctrl #(.N_DIGITS(N), .TICK_DIV(TD), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in), .load(load), .mode(mode),
    .dp_mask(dp_mask), .blank_lz(blank_lz), .brightness(brightness),
    .seg(seg), .anode(anode), .busy(busy), .overflow(overflow)
  );
  always #5 clk = ~clk;
  typedef struct {logic acc; logic dec; logic [31:0] digs; logic ovf;} exp_t;
  exp_t q[$];
  exp_t cur, pend;
  int checks = 0, fails = 0;
  logic mon_on = 0;
  int mp, mi, sw, age, bcnt;
  logic conv;
  logic p_en, p_blz;
  logic [7:0] p_dp;
  logic [3:0] p_br;
  logic [7:0] GL [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                          8'hFE, 8'hE6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(logic dec, logic [31:0] v);
    exp_t e;
    longint x = v;
    e.acc = 1; e.dec = dec; e.ovf = 0; e.digs = v;
    if (dec) begin
      if (x > 99999999) begin
        e.ovf = 1;
        e.digs = 32'hEEEEEEEE;
      end else begin
        e.digs = 0;
        for (int i = 0; i < N; i++) begin
          e.digs[4*i+:4] = 4'(x % 10);
          x = x / 10;
        end
      end
    end
    return e;
  endfunction

  function automatic logic [7:0] exp_seg(logic [31:0] digs, int i, logic blz, logic [7:0] dp);
    logic [7:0] g = GL[digs[4*i+:4]];
    if (blz && i > 0 && (digs >> (4 * i)) == 0) g = 8'h00;
    g[0] = g[0] | dp[i];
    return ~g;
  endfunction

  always @(negedge clk) if (mon_on) begin
    logic [7:0] es, ea;
    logic on;
    exp_t e;
    if (sw > 0) begin
      sw--;
      if (sw == 0) begin
        cur = pend;
        chk("overflow_after_load", overflow, cur.ovf);
      end
    end
    on = p_en && (mp / 2) <= p_br;
    ea = on ? ~(8'd1 << mi) : 8'hFF;
    es = on ? exp_seg(cur.digs, mi, p_blz, p_dp) : 8'hFF;
    chk("anode", anode, ea);
    chk("seg", seg, es);
    if (p_en) begin
      mp++;
      if (mp == TD) begin
        mp = 0;
        mi = (mi + 1) % N;
      end
    end
    if (conv) begin
      age++;
      if (busy) bcnt++;
      else begin
        chk("busy_len", bcnt, 32);
        chk("dec_overflow", overflow, pend.ovf);
        sw = 1;
        conv = 0;
      end
      if (conv && age > 64) begin
        chk("busy_timeout", busy, 0);
        sw = 1;
        conv = 0;
      end
    end
    if (load) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_load: got load with no expectation queued at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("busy_at_load", busy, !e.acc);
        if (e.acc) begin
          pend = e;
          if (e.dec) begin
            conv = 1;
            age = 0;
            bcnt = 0;
          end else sw = 2;
        end
      end
    end
    p_en = en; p_blz = blank_lz; p_dp = dp_mask; p_br = brightness;
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_load(logic dec, logic [31:0] v, logic acc);
    exp_t e = model(dec, v);
    e.acc = acc;
    mode = dec;
    data_in = v;
    load = 1;
    q.push_back(e);
    tick();
    load = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic dec;
    logic [31:0] v;
    en = 1;
    tick(3);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_anode", anode, 8'hFF);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    p_en = en; p_blz = blank_lz; p_dp = dp_mask; p_br = brightness;
    mp = 0; mi = 0; sw = 0; conv = 0; age = 0; bcnt = 0;
    cur = model(0, 0);
    mon_on = 1;
    push_load(0, 32'h1234ABCD, 1);
    tick(300);
    blank_lz = 1;
    push_load(1, 12345, 1);
    tick(300);
    blank_lz = 0;
    push_load(1, 32'hFFFFFFFF, 1);
    tick(300);
    brightness = 3;
    push_load(0, $urandom, 1);
    tick(300);
    brightness = 15;
    push_load(1, 987654, 1);
    tick(5);
    push_load(1, 111, 0);
    tick(300);
    for (int t = 0; t < 12; t++) begin
      dec = 1'($urandom);
      v = $urandom >> $urandom_range(0, 31);
      if (dec && $urandom_range(0, 3) == 0) v = $urandom;
      brightness = 4'($urandom);
      dp_mask = 8'($urandom);
      blank_lz = 1'($urandom);
      push_load(dec, v, 1);
      if (dec && 1'($urandom)) begin
        tick($urandom_range(0, 25));
        push_load(1'($urandom), $urandom, 0);
      end
      tick(300);
    end
    tick(2);
    mon_on = 0;
    chk("queue_empty", q.size(), 0);
    en = 0;
    tick(3);
    chk("en0_seg", seg, 8'hFF);
    chk("en0_anode", anode, 8'hFF);
    en = 1;
    mode = 1;
    data_in = 32'd99;
    load = 1;
    tick();
    load = 0;
    tick(10);
    chk("busy_before_rst", busy, 1);
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_seg", seg, 8'hFF);
    chk("async_rst_anode", anode, 8'hFF);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_overflow", overflow, 0);
    blank_lz = 0;
    dp_mask = 0;
    brightness = 15;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_seg", seg, 8'h03);
    chk("post_rst_anode", anode, 8'hFE);
    tick(40);
    chk("post_rst_busy", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
